instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage MIPS pipeline. Holds the PC and drives the instruction-memory address.
- Latches the fetched instruction and PC+4 towards ID. Obeys the load-use stall from the hazard detection unit and the branch/jump flush from ID.
- Detects the HALT instruction and freezes fetch. Exposes halted status and a fetch counter to the debug unit.

Parameters:
- NB_PC, 32, PC / address width.
- NB_INSTR, 32, instruction width.
- NB_COUNT, 32, fetch counter width.
- RESET_PC, 0, PC value after reset.
- HALT_OPCODE, 32'hFFFFFFFF, full-word HALT encoding.
- NOP_INSTR, 32'h00000000, bubble inserted into IF/ID.

Ports:
- i_clock  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  debug run/step enable; 0 freezes every register
- i_stall  in  1  load-use stall from hazard_detection_unit
- i_flush  in  1  taken branch/jump resolved in ID
- i_branch_target  in  NB_PC  redirect address, valid with i_flush
- i_instruction  in  NB_INSTR  instruction memory read data for o_pc (combinational read)
- o_pc  out  NB_PC  current fetch address to instruction memory
- o_pc_plus4_to_id  out  NB_PC  IF/ID: PC+4 of latched instruction
- o_instruction_to_id  out  NB_INSTR  IF/ID: latched instruction
- o_valid_to_id  out  1  IF/ID: latched instruction is real (not bubble)
- o_halted  out  1  HALT fetched; fetch frozen
- o_fetch_count  out  NB_COUNT  number of valid instructions latched into IF/ID

Behaviour:
- Reset, asynchronous, any time:
  - o_pc=RESET_PC, o_instruction_to_id=NOP_INSTR, o_pc_plus4_to_id=0, o_valid_to_id=0, o_halted=0, o_fetch_count=0.
  - State=RUN.
  - Reset mid-halt or mid-stall returns to RUN at RESET_PC.
- All registers update only on rising i_clock with i_enable=1. With i_enable=0 everything holds, including the counter.
- State machine RUN / HALTED. Priority in RUN, highest first:
  - i_stall=1: PC holds and IF/ID holds. i_flush is ignored; ID must not assert flush while stalled. No count.
  - i_flush=1: PC<=i_branch_target; IF/ID<=NOP_INSTR, valid=0, pc_plus4=0. No count. A HALT present on i_instruction is wrong-path: discarded, state stays RUN.
  - i_instruction==HALT_OPCODE: IF/ID<=HALT, valid=1, pc_plus4=o_pc+4. PC holds. Count+1. State<=HALTED.
  - Otherwise: IF/ID<=i_instruction, valid=1, pc_plus4=o_pc+4. PC<=o_pc+4. Count+1.
- HALTED:
  - PC holds. i_stall and i_flush are ignored.
  - On the first HALTED cycle with i_stall=0, IF/ID<=NOP_INSTR and valid=0, so HALT enters ID exactly once. No count.
  - o_halted=1. Exit only by reset.
- Latency:
  - Instruction at o_pc appears on o_instruction_to_id one enabled cycle later.
  - A flush costs one bubble.
  - A stall holds the same IF/ID contents for as long as i_stall stays high.
- Arithmetic:
  - PC+4 is modulo 2^NB_PC; 0xFFFFFFFC wraps to 0, with no flag.
  - i_branch_target is used as given; word alignment is the producer's responsibility.
  - o_fetch_count wraps modulo 2^NB_COUNT.
- Stall during HALT detection: a stall with HALT on i_instruction holds. HALT is processed on the first unstalled cycle.
- All outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Shared package/header:
  - NB_PC and NB_INSTR defaults, HALT_OPCODE, NOP_INSTR.
  - RUN/HALTED state encoding, localparam 1-bit.
  - PC_INCREMENT=4.
- One natural sub-module: if_id_pipeline_register. It holds instruction, pc_plus4 and valid, with enable, hold (stall) and clear (bubble) inputs, and is reused by later stage registers.
- PC register, next-PC mux, halt FSM and counter stay in the top.

Test Plan:
- Reset then enable with memory words 0x20010005, 0x20020003 at 0 and 4 -> cycle1 o_pc=4, IF/ID=0x20010005, pc_plus4=4, valid=1; cycle2 o_pc=8, IF/ID=0x20020003, count=2.
- i_stall=1 for 2 cycles at o_pc=8 -> o_pc stays 8, IF/ID unchanged, count unchanged; resumes on release with no instruction lost.
- i_flush=1, target=0x40 at o_pc=0x10 -> next cycle o_pc=0x40, IF/ID=NOP, valid=0, count unchanged; following cycle IF/ID=mem[0x40].
- Stall and flush together -> stall wins: o_pc unchanged, IF/ID unchanged, target ignored.
- HALT at 0x0C -> IF/ID=0xFFFFFFFF, valid=1, o_halted=1, o_pc stays 0x0C; next cycle valid=0; flush/stall then ignored; count frozen.
- Flush coinciding with HALT on i_instruction -> HALT discarded, o_halted=0, PC=target. Also: i_enable=0 for 3 cycles freezes everything; async reset while HALTED returns o_pc=RESET_PC and o_halted=0 without a clock edge.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and state encoding for the IF stage and its IF/ID register.
package instruction_fetch_unit_pkg;

  localparam int unsigned NB_PC_DEF    = 32;
  localparam int unsigned NB_INSTR_DEF = 32;
  localparam int unsigned NB_COUNT_DEF = 32;

  localparam logic [NB_INSTR_DEF-1:0] HALT_OPCODE_DEF = 32'hFFFF_FFFF;
  localparam logic [NB_INSTR_DEF-1:0] NOP_INSTR_DEF   = 32'h0000_0000;

  localparam int unsigned PC_INCREMENT = 4;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: control inputs, instruction-memory bus and IF/ID outputs.
// Handshake: no valid/ready; o_valid_to_id qualifies IF/ID contents, i_flush qualifies i_branch_target.
interface instruction_fetch_unit_if #(
  parameter int unsigned NB_PC    = 32,
  parameter int unsigned NB_INSTR = 32,
  parameter int unsigned NB_COUNT = 32
);
  logic                i_enable;
  logic                i_stall;
  logic                i_flush;
  logic [NB_PC-1:0]    i_branch_target;
  logic [NB_INSTR-1:0] i_instruction;
  logic [NB_PC-1:0]    o_pc;
  logic [NB_PC-1:0]    o_pc_plus4_to_id;
  logic [NB_INSTR-1:0] o_instruction_to_id;
  logic                o_valid_to_id;
  logic                o_halted;
  logic [NB_COUNT-1:0] o_fetch_count;

  modport slave (
    input  i_enable, i_stall, i_flush, i_branch_target, i_instruction,
    output o_pc, o_pc_plus4_to_id, o_instruction_to_id, o_valid_to_id,
           o_halted, o_fetch_count
  );

  modport master (
    output i_enable, i_stall, i_flush, i_branch_target, i_instruction,
    input  o_pc, o_pc_plus4_to_id, o_instruction_to_id, o_valid_to_id,
           o_halted, o_fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit_if_id.sv
// Generic stage register: hold beats clear, clear beats load; nothing moves without enable.
module if_id_pipeline_register
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned          NB_PC     = NB_PC_DEF,
  parameter int unsigned          NB_INSTR  = NB_INSTR_DEF,
  parameter logic [NB_INSTR-1:0]  NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_hold,
  input  logic                i_clear,
  input  logic [NB_INSTR-1:0] i_instruction,
  input  logic [NB_PC-1:0]    i_pc_plus4,
  output logic [NB_INSTR-1:0] o_instruction,
  output logic [NB_PC-1:0]    o_pc_plus4,
  output logic                o_valid
);
  logic [NB_INSTR-1:0] instr_q, instr_d;
  logic [NB_PC-1:0]    pc_plus4_q, pc_plus4_d;
  logic                valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (!i_hold) begin
      if (i_clear) begin
        instr_d    = NOP_INSTR;
        pc_plus4_d = '0;
        valid_d    = 1'b0;
      end else begin
        instr_d    = i_instruction;
        pc_plus4_d = i_pc_plus4;
        valid_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (i_enable) begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign o_instruction = instr_q;
  assign o_pc_plus4    = pc_plus4_q;
  assign o_valid       = valid_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: PC register, next-PC selection, HALT freeze FSM and fetch counter feeding the IF/ID register.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned          NB_PC       = NB_PC_DEF,
  parameter int unsigned          NB_INSTR    = NB_INSTR_DEF,
  parameter int unsigned          NB_COUNT    = NB_COUNT_DEF,
  parameter logic [NB_PC-1:0]     RESET_PC    = '0,
  parameter logic [NB_INSTR-1:0]  HALT_OPCODE = HALT_OPCODE_DEF,
  parameter logic [NB_INSTR-1:0]  NOP_INSTR   = NOP_INSTR_DEF
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  instruction_fetch_unit_if.slave   bus
);
  localparam logic [NB_PC-1:0] PC_INC = NB_PC'(PC_INCREMENT);

  fetch_state_e        state_q, state_d;
  logic [NB_PC-1:0]    pc_q, pc_d;
  logic [NB_COUNT-1:0] count_q, count_d;
  logic [NB_PC-1:0]    pc_plus4;
  logic                reg_hold, reg_clear;

  assign pc_plus4 = pc_q + PC_INC;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    reg_hold  = 1'b0;
    reg_clear = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.i_stall) begin
          reg_hold = 1'b1;
        end else if (bus.i_flush) begin
          // Wrong-path fetch, including a HALT, is dropped in favour of the redirect.
          pc_d      = bus.i_branch_target;
          reg_clear = 1'b1;
        end else if (bus.i_instruction == HALT_OPCODE) begin
          state_d = HALTED;
          count_d = count_q + 1'b1;
        end else begin
          pc_d    = pc_plus4;
          count_d = count_q + 1'b1;
        end
      end
      HALTED: begin
        // HALT goes to ID once; afterwards IF/ID stays a bubble until reset.
        reg_hold  = bus.i_stall;
        reg_clear = ~bus.i_stall;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else if (bus.i_enable) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  if_id_pipeline_register #(
    .NB_PC     (NB_PC),
    .NB_INSTR  (NB_INSTR),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_enable      (bus.i_enable),
    .i_hold        (reg_hold),
    .i_clear       (reg_clear),
    .i_instruction (bus.i_instruction),
    .i_pc_plus4    (pc_plus4),
    .o_instruction (bus.o_instruction_to_id),
    .o_pc_plus4    (bus.o_pc_plus4_to_id),
    .o_valid       (bus.o_valid_to_id)
  );

  assign bus.o_pc          = pc_q;
  assign bus.o_halted      = (state_q == HALTED);
  assign bus.o_fetch_count = count_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a queue-based scoreboard.
module tb_instruction_fetch_unit;
  localparam int W = 32 * 4 + 2;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk;
  logic rst;
  logic [31:0] mem [64];

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  instruction_fetch_unit_if #(.NB_PC(32), .NB_INSTR(32), .NB_COUNT(32)) bus ();

  instruction_fetch_unit dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  assign bus.i_instruction = mem[bus.o_pc[7:2]];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // driver tasks
  task automatic idle();
    @(negedge clk);
    bus.i_enable = 1'b0;
    bus.i_stall  = 1'b0;
    bus.i_flush  = 1'b0;
  endtask

  task automatic step(input logic en, input logic st, input logic fl, input logic [31:0] tgt,
                      input logic [31:0] e_pc, input logic [31:0] e_instr, input logic [31:0] e_pc4,
                      input logic e_v, input logic e_h, input logic [31:0] e_cnt);
    @(negedge clk);
    bus.i_enable        = en;
    bus.i_stall         = st;
    bus.i_flush         = fl;
    bus.i_branch_target = tgt;
    exp_q.push_back({e_pc, e_instr, e_pc4, e_v, e_h, e_cnt});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"},    bus.o_pc, 32'h0);
    check({tag, "_instr"}, bus.o_instruction_to_id, 32'h0);
    check({tag, "_pc4"},   bus.o_pc_plus4_to_id, 32'h0);
    check({tag, "_valid"}, {31'b0, bus.o_valid_to_id}, 32'h0);
    check({tag, "_halt"},  {31'b0, bus.o_halted}, 32'h0);
    check({tag, "_count"}, bus.o_fetch_count, 32'h0);
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pc",    bus.o_pc,                 e[129:98]);
      check("instr", bus.o_instruction_to_id,  e[97:66]);
      check("pc4",   bus.o_pc_plus4_to_id,     e[65:34]);
      check("valid", {31'b0, bus.o_valid_to_id}, {31'b0, e[33]});
      check("halt",  {31'b0, bus.o_halted},      {31'b0, e[32]});
      check("count", bus.o_fetch_count,        e[31:0]);
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h2400_0000 | 32'(i);
    mem[0]  = 32'h2001_0005;
    mem[1]  = 32'h2002_0003;
    mem[2]  = 32'h2003_0007;
    mem[3]  = 32'h2004_0009;
    mem[4]  = 32'h2005_000B;
    mem[16] = 32'h8C01_0000;
    mem[17] = 32'h8C02_0004;
    bus.i_enable = 1'b0;
    bus.i_stall  = 1'b0;
    bus.i_flush  = 1'b0;
    bus.i_branch_target = 32'h0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // sequential fetch, stall, stall+flush, flush, enable freeze
    step(1,0,0,0,         32'h04, 32'h2001_0005, 32'h04, 1,0, 1);
    step(1,0,0,0,         32'h08, 32'h2002_0003, 32'h08, 1,0, 2);
    step(1,1,0,0,         32'h08, 32'h2002_0003, 32'h08, 1,0, 2);
    step(1,1,0,0,         32'h08, 32'h2002_0003, 32'h08, 1,0, 2);
    step(1,0,0,0,         32'h0C, 32'h2003_0007, 32'h0C, 1,0, 3);
    step(1,1,1,32'h80,    32'h0C, 32'h2003_0007, 32'h0C, 1,0, 3);
    step(1,0,0,0,         32'h10, 32'h2004_0009, 32'h10, 1,0, 4);
    step(1,0,1,32'h40,    32'h40, 32'h0,         32'h0,  0,0, 4);
    step(1,0,0,0,         32'h44, 32'h8C01_0000, 32'h44, 1,0, 5);
    step(0,0,0,0,         32'h44, 32'h8C01_0000, 32'h44, 1,0, 5);
    step(0,1,1,32'h99,    32'h44, 32'h8C01_0000, 32'h44, 1,0, 5);
    step(0,0,0,0,         32'h44, 32'h8C01_0000, 32'h44, 1,0, 5);
    step(1,0,0,0,         32'h48, 32'h8C02_0004, 32'h48, 1,0, 6);
    mem[18] = HALT;
    step(1,0,1,32'h20,    32'h20, 32'h0,         32'h0,  0,0, 6);
    step(1,0,0,0,         32'h24, 32'h2400_0008, 32'h24, 1,0, 7);
    idle();

    // async reset mid-run, then HALT at 0x0C
    rst = 1'b1;
    #1;
    check_reset_state("arst_run");
    @(negedge clk);
    rst = 1'b0;
    mem[3] = HALT;
    step(1,0,0,0,         32'h04, 32'h2001_0005, 32'h04, 1,0, 1);
    step(1,0,0,0,         32'h08, 32'h2002_0003, 32'h08, 1,0, 2);
    step(1,0,0,0,         32'h0C, 32'h2003_0007, 32'h0C, 1,0, 3);
    step(1,1,0,0,         32'h0C, 32'h2003_0007, 32'h0C, 1,0, 3);
    step(1,0,0,0,         32'h0C, HALT,          32'h10, 1,1, 4);
    step(1,0,0,0,         32'h0C, 32'h0,         32'h0,  0,1, 4);
    step(1,0,1,32'h40,    32'h0C, 32'h0,         32'h0,  0,1, 4);
    step(1,1,0,0,         32'h0C, 32'h0,         32'h0,  0,1, 4);
    step(1,0,0,0,         32'h0C, 32'h0,         32'h0,  0,1, 4);
    idle();

    // async reset while halted, then PC wrap at the top of the address space
    rst = 1'b1;
    #1;
    check_reset_state("arst_halt");
    @(negedge clk);
    rst = 1'b0;
    step(1,0,1,32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         32'h0, 0,0, 0);
    step(1,0,0,0,             32'h0,         32'h2400_003F, 32'h0, 1,0, 1);
    idle();

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
